// File: rtl/transposer_sched_pkg.sv
// Shared types and helpers for the transposer sequencer and its input buffer.
package transposer_sched_pkg;

  localparam int unsigned NUM_WORDS_DEF = 64;
  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned MAX_PREC_DEF  = 16;
  localparam int unsigned BUF_DEPTH     = NUM_WORDS_DEF * MAX_PREC_DEF / XLEN_DEF;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    START,
    STREAM,
    WAIT_HI,
    WAIT_LO
  } sched_state_t;

  function automatic logic prec_legal(input logic [4:0] prec);
    return (prec == 5'd2) || (prec == 5'd4) || (prec == 5'd8) || (prec == 5'd16);
  endfunction

  function automatic int unsigned words_per_block(input logic [4:0] prec,
                                                  input int unsigned num_words,
                                                  input int unsigned xlen);
    return (num_words * 32'(prec)) / xlen;
  endfunction

endpackage

// File: rtl/transposer_word_fifo.sv
// Show-ahead synchronous word FIFO with occupancy output; reset flushes contents.
module transposer_word_fifo
  import transposer_sched_pkg::*;
#(
  parameter int unsigned DEPTH = BUF_DEPTH,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [OCC_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign wr_en = push && (count < OCC_W'(DEPTH));
  assign rd_en = pop && (count != '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/transposer_sched.sv
// Buffers one block of input words, then fires the transposer and streams the
// block without stalls, stepping the MVU address block by block.
module transposer_sched
  import transposer_sched_pkg::*;
#(
  parameter int unsigned NUM_WORDS     = 64,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned MVU_ADDR_LEN  = 32,
  parameter int unsigned MAX_DATA_PREC = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [4:0]              cmd_prec,
  input  logic [MVU_ADDR_LEN-1:0] cmd_baddr,
  input  logic [CNT_W-1:0]        cmd_nblk,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_word,
  output logic                    tp_start,
  output logic [31:0]             tp_prec,
  output logic [MVU_ADDR_LEN-1:0] tp_baddr,
  output logic [XLEN-1:0]         tp_iword,
  input  logic                    tp_busy,
  output logic                    job_done,
  output logic                    cmd_err,
  output logic                    sched_busy
);

  localparam int unsigned DEPTH = NUM_WORDS * MAX_DATA_PREC / XLEN;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  sched_state_t      state, state_nx;
  logic [4:0]        prec_q;
  logic [CNT_W-1:0]  blk_cnt, last_blk;
  logic [OCC_W-1:0]  occ, occ_nx, wpb, wpb_nx;
  logic [XLEN-1:0]   fifo_rdata;
  logic              legal, cmd_acc, last, push, pop;
  logic              cmd_ready_d, in_ready_d, tp_start_d, job_done_d, cmd_err_d, sched_busy_d;
  logic [XLEN-1:0]   tp_iword_d;

  assign legal   = prec_legal(cmd_prec);
  assign cmd_acc = (state == IDLE) && cmd_valid && cmd_ready;
  assign last    = (blk_cnt == last_blk);
  assign push    = in_valid && in_ready;
  assign pop     = (state == START) || (state == STREAM);
  assign wpb     = OCC_W'(words_per_block(prec_q, NUM_WORDS, XLEN));
  assign wpb_nx  = OCC_W'(words_per_block(cmd_acc ? cmd_prec : prec_q, NUM_WORDS, XLEN));
  assign occ_nx  = occ + OCC_W'(push) - OCC_W'(pop);

  transposer_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN),
    .OCC_W (OCC_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_word),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (occ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // STREAM sees no pushes, so occupancy 1 means this cycle pops the last word.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cmd_acc && legal) state_nx = FILL;
      FILL:    if (occ == wpb) state_nx = START;
      START:   state_nx = STREAM;
      STREAM:  if (occ == OCC_W'(1)) state_nx = WAIT_HI;
      WAIT_HI: if (tp_busy) state_nx = WAIT_LO;
      WAIT_LO: if (!tp_busy) state_nx = last ? IDLE : FILL;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state; prefetch
  // during the wait states is suppressed on the last block of a job.
  always_comb begin
    cmd_ready_d  = (state_nx == IDLE);
    sched_busy_d = (state_nx != IDLE);
    tp_start_d   = (state_nx == START);
    in_ready_d   = ((state_nx == FILL) ||
                    (((state_nx == WAIT_HI) || (state_nx == WAIT_LO)) && !last)) &&
                   (occ_nx < wpb_nx);
    job_done_d   = (state == WAIT_LO) && !tp_busy && last;
    cmd_err_d    = cmd_acc && !legal;
    tp_iword_d   = pop ? fifo_rdata : tp_iword;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready  <= 1'b0;
      in_ready   <= 1'b0;
      tp_start   <= 1'b0;
      job_done   <= 1'b0;
      cmd_err    <= 1'b0;
      sched_busy <= 1'b0;
      tp_iword   <= '0;
      tp_prec    <= '0;
      tp_baddr   <= '0;
      prec_q     <= '0;
      blk_cnt    <= '0;
      last_blk   <= '0;
    end else begin
      cmd_ready  <= cmd_ready_d;
      in_ready   <= in_ready_d;
      tp_start   <= tp_start_d;
      job_done   <= job_done_d;
      cmd_err    <= cmd_err_d;
      sched_busy <= sched_busy_d;
      tp_iword   <= tp_iword_d;
      if (cmd_acc && legal) begin
        prec_q   <= cmd_prec;
        tp_prec  <= 32'(cmd_prec);
        tp_baddr <= cmd_baddr;
        blk_cnt  <= '0;
        last_blk <= (cmd_nblk == '0) ? '0 : cmd_nblk - 1'b1;
      end else if ((state == WAIT_LO) && !tp_busy && !last) begin
        blk_cnt  <= blk_cnt + 1'b1;
        tp_baddr <= tp_baddr + MVU_ADDR_LEN'(prec_q);
      end
    end
  end

endmodule

// File: tb/tb_transposer_sched.sv
// Directed and randomized jobs checked against a block/word reference model.
module tb_transposer_sched;

  localparam int NW = 64;
  localparam int XL = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_prec = '0;
  logic [31:0] cmd_baddr = '0;
  logic [15:0] cmd_nblk = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = '0;
  logic        tp_start;
  logic [31:0] tp_prec;
  logic [31:0] tp_baddr;
  logic [31:0] tp_iword;
  logic        tp_busy = 1'b0;
  logic        job_done;
  logic        cmd_err;
  logic        sched_busy;

  int tests = 0;
  int fails = 0;
  logic [31:0] sent[$];
  int accepted;
  logic [4:0] precs[4] = '{5'd2, 5'd4, 5'd8, 5'd16};

  always #5 clk = ~clk;

  transposer_sched #(
    .NUM_WORDS     (64),
    .XLEN          (32),
    .MVU_ADDR_LEN  (32),
    .MAX_DATA_PREC (16),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_prec   (cmd_prec),
    .cmd_baddr  (cmd_baddr),
    .cmd_nblk   (cmd_nblk),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .tp_start   (tp_start),
    .tp_prec    (tp_prec),
    .tp_baddr   (tp_baddr),
    .tp_iword   (tp_iword),
    .tp_busy    (tp_busy),
    .job_done   (job_done),
    .cmd_err    (cmd_err),
    .sched_busy (sched_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_tp_start"}, tp_start, 0);
    chk({tag, "_tp_iword"}, tp_iword, 0);
    chk({tag, "_tp_baddr"}, tp_baddr, 0);
    chk({tag, "_tp_prec"}, tp_prec, 0);
    chk({tag, "_job_done"}, job_done, 0);
    chk({tag, "_cmd_err"}, cmd_err, 0);
    chk({tag, "_sched_busy"}, sched_busy, 0);
  endtask

  task automatic issue_cmd(input logic [4:0] prec, input logic [31:0] baddr, input logic [15:0] nblk);
    int guard = 0;
    cmd_valid = 1'b1;
    cmd_prec  = prec;
    cmd_baddr = baddr;
    cmd_nblk  = nblk;
    while (!cmd_ready && guard < 100) begin
      tick();
      guard++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Model: block b starts at baddr + b*prec (mod 2^32) and streams input words
  // b*WPB .. b*WPB+WPB-1 in arrival order, with WPB = NW*prec/XL.
  task automatic run_job(input logic [4:0] prec, input logic [31:0] baddr,
                         input logic [15:0] nblk, input int gap);
    int nb    = (nblk == 0) ? 1 : int'(nblk);
    int wpb   = NW * int'(prec) / XL;
    int total = nb * wpb;
    sent.delete();
    accepted = 0;
    issue_cmd(prec, baddr, nblk);
    chk("in_ready_after_cmd", in_ready, 1);
    chk("busy_after_cmd", sched_busy, 1);
    chk("cmd_ready_in_job", cmd_ready, 0);
    fork
      begin : producer
        logic [31:0] w;
        int g;
        w = $urandom;
        g = 0;
        while (accepted < total && g < 5000) begin
          case (gap)
            0:       in_valid = 1'b1;
            1:       in_valid = g[0];
            default: in_valid = 1'($urandom_range(0, 1));
          endcase
          in_word = w;
          if (in_valid && in_ready) begin
            sent.push_back(w);
            accepted++;
            w = $urandom;
          end
          tick();
          g++;
        end
        in_valid = 1'b0;
        chk("producer_done", accepted, total);
      end
      begin : consumer
        for (int b = 0; b < nb; b++) begin
          int g;
          int d;
          int hi;
          logic [31:0] eb;
          g = 0;
          while (!tp_start && g < 3000) begin
            tick();
            g++;
          end
          chk("start_seen", tp_start, 1);
          eb = baddr + 32'(b) * 32'(prec);
          chk("blk_baddr", tp_baddr, eb);
          chk("tp_prec", tp_prec, 64'(prec));
          chk("words_before_start", accepted, (b + 1) * wpb);
          chk("in_ready_at_start", in_ready, 0);
          chk("cmd_held_off", cmd_ready, 0);
          for (int k = 0; k < wpb; k++) begin
            tick();
            if (k == 0) chk("start_pulse_len", tp_start, 0);
            chk("stream_word", tp_iword, sent[b * wpb + k]);
          end
          d = $urandom_range(0, 3);
          repeat (d) tick();
          tp_busy = 1'b1;
          hi = $urandom_range(1, 4);
          repeat (hi) tick();
          tp_busy = 1'b0;
          chk("tp_iword_hold", tp_iword, sent[b * wpb + wpb - 1]);
          chk("no_early_done", job_done, 0);
          if (b == nb - 1) begin
            int extra;
            tick();
            chk("job_done", job_done, 1);
            chk("idle_after_done", sched_busy, 0);
            chk("cmd_ready_after_done", cmd_ready, 1);
            tick();
            chk("job_done_pulse", job_done, 0);
            extra = 0;
            repeat (6) begin
              tick();
              if (tp_start) extra++;
            end
            chk("no_extra_block", extra, 0);
          end
        end
      end
    join
  endtask

  initial begin
    int g;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    tick();
    chk("cmd_ready_rise", cmd_ready, 1);

    run_job(5'd2, 32'h100, 16'd1, 0);
    run_job(5'd8, 32'h100, 16'd3, 1);

    cmd_valid = 1'b1;
    cmd_prec  = 5'd6;
    cmd_baddr = 32'h400;
    cmd_nblk  = 16'd1;
    tick();
    cmd_valid = 1'b0;
    chk("cmd_err_pulse", cmd_err, 1);
    chk("illegal_in_ready", in_ready, 0);
    chk("illegal_idle", sched_busy, 0);
    chk("illegal_cmd_ready", cmd_ready, 1);
    tick();
    chk("cmd_err_clear", cmd_err, 0);
    chk("illegal_in_ready2", in_ready, 0);
    run_job(5'd4, 32'h200, 16'd1, 2);

    run_job(5'd16, 32'h100, 16'd2, 0);

    issue_cmd(5'd4, 32'h300, 16'd2);
    g = 0;
    while (!tp_start && g < 500) begin
      in_valid = 1'b1;
      in_word  = $urandom;
      tick();
      g++;
    end
    in_valid = 1'b0;
    chk("midrst_start_seen", tp_start, 1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    tick();
    rst_n = 1'b1;
    chk("midrst_cmd_ready_low", cmd_ready, 0);
    tick();
    chk("midrst_cmd_ready_rise", cmd_ready, 1);
    chk("midrst_no_done", job_done, 0);
    run_job(5'd4, 32'h300, 16'd2, 2);

    run_job(5'd4, 32'hFFFF_FFFC, 16'd2, 1);
    run_job(precs[$urandom_range(0, 3)], $urandom, 16'd0, 2);

    repeat (4) run_job(precs[$urandom_range(0, 3)], $urandom, 16'($urandom_range(1, 3)),
                       $urandom_range(0, 2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
